// File: rtl/rtc_edit_sequencer.sv
// Edit-mode sequencer for the six BCD RTC field registers: field selection,
// UP/DOWN pulse generation with auto-repeat, Actualizar gating and write-back.
module rtc_edit_sequencer #(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int TIMEOUT      = 1_000_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EDIT,
  input  logic       NEXT,
  input  logic       UP_IN,
  input  logic       DOWN_IN,
  input  logic       RD_STB,
  input  logic       WR_ACK,
  output logic [5:0] MOD,
  output logic       UP,
  output logic       DOWN,
  output logic       ACT,
  output logic       WR_REQ,
  output logic [2:0] WR_SEL,
  output logic       EDITING
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [RW-1:0] DELAY_V = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_V  = RW'(REPEAT_RATE);
  localparam logic [RW-1:0] R_SAT   = RW'(RMAX);
  localparam logic [RW-1:0] R_ONE   = RW'(1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [2:0]    LAST_SEL = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

  state_t           state_reg;
  logic [5:0]       mod_reg;
  logic             up_reg;
  logic             down_reg;
  logic             act_reg;
  logic             wr_req_reg;
  logic [2:0]       wr_sel_reg;
  logic             editing_reg;
  logic [TW-1:0]    idle_cnt_reg;

  // Index 0 is the UP button, index 1 the DOWN button.
  logic [1:0][RW-1:0] rpt_cnt_reg;
  logic [1:0]         rpt_rep_reg;
  logic [1:0][RW-1:0] rpt_cnt_next;
  logic [1:0]         rpt_rep_next;
  logic [1:0]         hit;
  logic [1:0]         held;

  // UP has priority: DOWN only counts while UP is released.
  assign held = {DOWN_IN & ~UP_IN, UP_IN};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
      logic          blk_hit;
      logic [RW-1:0] blk_cnt;
      logic          blk_rep;

      // cnt==0 means "not held", so the first held cycle is the rising edge.
      always_comb begin
        blk_hit = 1'b0;
        blk_cnt = '0;
        blk_rep = 1'b0;
        if (held[gi]) begin
          if (rpt_cnt_reg[gi] == '0) begin
            blk_hit = 1'b1;
            blk_cnt = R_ONE;
          end else if (!rpt_rep_reg[gi] && rpt_cnt_reg[gi] == DELAY_V) begin
            blk_hit = 1'b1;
            blk_cnt = R_ONE;
            blk_rep = 1'b1;
          end else if (rpt_rep_reg[gi] && rpt_cnt_reg[gi] == RATE_V) begin
            blk_hit = 1'b1;
            blk_cnt = R_ONE;
            blk_rep = 1'b1;
          end else begin
            blk_cnt = (rpt_cnt_reg[gi] == R_SAT) ? rpt_cnt_reg[gi] : rpt_cnt_reg[gi] + R_ONE;
            blk_rep = rpt_rep_reg[gi];
          end
        end
      end

      assign hit[gi]          = blk_hit;
      assign rpt_cnt_next[gi] = blk_cnt;
      assign rpt_rep_next[gi] = blk_rep;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      mod_reg      <= '0;
      up_reg       <= 1'b0;
      down_reg     <= 1'b0;
      act_reg      <= 1'b0;
      wr_req_reg   <= 1'b0;
      wr_sel_reg   <= '0;
      editing_reg  <= 1'b0;
      idle_cnt_reg <= '0;
      rpt_cnt_reg  <= '0;
      rpt_rep_reg  <= '0;
    end else begin
      up_reg   <= 1'b0;
      down_reg <= 1'b0;
      act_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (EDIT) begin
            state_reg    <= S_EDIT;
            mod_reg      <= 6'b000001;
            editing_reg  <= 1'b1;
            idle_cnt_reg <= '0;
          end else begin
            act_reg <= RD_STB;
          end
        end
        S_EDIT: begin
          if (EDIT) begin
            state_reg    <= S_COMMIT;
            mod_reg      <= '0;
            editing_reg  <= 1'b0;
            wr_req_reg   <= 1'b1;
            wr_sel_reg   <= '0;
            idle_cnt_reg <= '0;
            rpt_cnt_reg  <= '0;
            rpt_rep_reg  <= '0;
          end else if (idle_cnt_reg == TO_LAST) begin
            // Abandon edits; the next RD_STB reloads the field registers.
            state_reg    <= S_IDLE;
            mod_reg      <= '0;
            editing_reg  <= 1'b0;
            idle_cnt_reg <= '0;
            rpt_cnt_reg  <= '0;
            rpt_rep_reg  <= '0;
          end else if (NEXT) begin
            mod_reg      <= {mod_reg[4:0], mod_reg[5]};
            idle_cnt_reg <= '0;
            rpt_cnt_reg  <= '0;
            rpt_rep_reg  <= '0;
          end else begin
            up_reg       <= hit[0];
            down_reg     <= hit[1];
            rpt_cnt_reg  <= rpt_cnt_next;
            rpt_rep_reg  <= rpt_rep_next;
            if (|hit)
              idle_cnt_reg <= '0;
            else if (idle_cnt_reg != TO_LAST)
              idle_cnt_reg <= idle_cnt_reg + T_ONE;
          end
        end
        S_COMMIT: begin
          if (wr_req_reg && WR_ACK) begin
            if (wr_sel_reg == LAST_SEL) begin
              wr_req_reg <= 1'b0;
              wr_sel_reg <= '0;
              state_reg  <= S_IDLE;
            end else begin
              wr_sel_reg <= wr_sel_reg + 3'd1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign MOD     = mod_reg;
  assign UP      = up_reg;
  assign DOWN    = down_reg;
  assign ACT     = act_reg;
  assign WR_REQ  = wr_req_reg;
  assign WR_SEL  = wr_sel_reg;
  assign EDITING = editing_reg;

endmodule

// File: tb/tb_rtc_edit_sequencer.sv
// Table-driven bench for rtc_edit_sequencer: vectors feed a scoreboard queue that a
// monitor drains one record per clock; reset-during-commit is checked by hand.
module tb_rtc_edit_sequencer;

  localparam int P_DELAY = 8;
  localparam int P_RATE  = 4;
  localparam int P_TO    = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EDIT = 1'b0, NEXT = 1'b0, UP_IN = 1'b0, DOWN_IN = 1'b0, RD_STB = 1'b0, WR_ACK = 1'b0;
  logic [5:0] MOD;
  logic       UP, DOWN, ACT, WR_REQ, EDITING;
  logic [2:0] WR_SEL;
  logic [13:0] obs;

  always #5 CLK = ~CLK;

  rtc_edit_sequencer #(
    .REPEAT_DELAY(P_DELAY),
    .REPEAT_RATE (P_RATE),
    .TIMEOUT     (P_TO)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .EDIT   (EDIT),
    .NEXT   (NEXT),
    .UP_IN  (UP_IN),
    .DOWN_IN(DOWN_IN),
    .RD_STB (RD_STB),
    .WR_ACK (WR_ACK),
    .MOD    (MOD),
    .UP     (UP),
    .DOWN   (DOWN),
    .ACT    (ACT),
    .WR_REQ (WR_REQ),
    .WR_SEL (WR_SEL),
    .EDITING(EDITING)
  );

  assign obs = {MOD, UP, DOWN, ACT, WR_REQ, WR_SEL, EDITING};

  typedef struct {
    logic        edit, next, up_in, down_in, rd_stb, wr_ack;
    logic [13:0] exp;
    int          idx;
  } vec_t;

  vec_t  tbl[$];
  string names[$];
  vec_t  sb_q[$];
  vec_t  mon_v;
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  found;

  function automatic logic [13:0] pk(logic [5:0] m, logic u, logic d, logic a,
                                     logic rq, logic [2:0] s, logic ed);
    return {m, u, d, a, rq, s, ed};
  endfunction

  function automatic logic [13:0] e_idle(logic a);
    return pk(6'b0, 1'b0, 1'b0, a, 1'b0, 3'd0, 1'b0);
  endfunction

  function automatic logic [13:0] e_edit(logic [5:0] m, logic u, logic d);
    return pk(m, u, d, 1'b0, 1'b0, 3'd0, 1'b1);
  endfunction

  function automatic logic [13:0] e_com(logic [2:0] s);
    return pk(6'b0, 1'b0, 1'b0, 1'b0, 1'b1, s, 1'b0);
  endfunction

  task automatic add(string nm, logic e, logic n, logic u, logic d, logic r, logic a,
                     logic [13:0] x);
    vec_t v;
    v.edit = e; v.next = n; v.up_in = u; v.down_in = d; v.rd_stb = r; v.wr_ack = a;
    v.exp = x;
    v.idx = tbl.size();
    tbl.push_back(v);
    names.push_back(nm);
  endtask

  task automatic check(string nm, logic [13:0] got, logic [13:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got mod=%b up=%b dn=%b act=%b req=%b sel=%0d ed=%b, expected mod=%b up=%b dn=%b act=%b req=%b sel=%0d ed=%b",
               nm, got[13:8], got[7], got[6], got[5], got[4], got[3:1], got[0],
               want[13:8], want[7], want[6], want[5], want[4], want[3:1], want[0]);
    end else begin
      $display("pass %s: mod=%b up=%b dn=%b act=%b req=%b sel=%0d ed=%b",
               nm, got[13:8], got[7], got[6], got[5], got[4], got[3:1], got[0]);
    end
  endtask

  // Monitor: one scoreboard record per clock, sampled 1 ns after the edge.
  always @(posedge CLK) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_v = sb_q.pop_front();
      check($sformatf("%s[%0d]", names[mon_v.idx], mon_v.idx), obs, mon_v.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- stimulus table ----
    add("idle_quiet",    0,0,0,0,0,0, e_idle(1'b0));
    add("idle_rd",       0,0,0,0,1,0, e_idle(1'b1));
    add("idle_act_end",  0,0,0,0,0,0, e_idle(1'b0));
    add("idle_ignore",   0,1,1,1,0,0, e_idle(1'b0));
    add("idle_release",  0,0,0,0,0,0, e_idle(1'b0));
    add("enter_edit_rd", 1,0,0,0,1,0, e_edit(6'b000001, 1'b0, 1'b0));
    add("edit_rd_gated", 0,0,0,0,1,0, e_edit(6'b000001, 1'b0, 1'b0));
    for (int k = 1; k <= 6; k++)
      add("next_rotate", 0,1,0,0,0,0, e_edit(6'(1 << (k % 6)), 1'b0, 1'b0));
    add("next_with_up",  0,1,1,0,0,0, e_edit(6'b000010, 1'b0, 1'b0));
    add("after_next_up", 0,0,0,0,0,0, e_edit(6'b000010, 1'b0, 1'b0));
    for (int j = 0; j < 20; j++)
      add("up_hold", 0,0,1,0,0,0, e_edit(6'b000010, (j == 0 || j == 8 || j == 12 || j == 16), 1'b0));
    add("up_release",    0,0,0,0,0,0, e_edit(6'b000010, 1'b0, 1'b0));
    for (int j = 0; j < 10; j++)
      add("both_hold", 0,0,1,1,0,0, e_edit(6'b000010, (j == 0 || j == 8), 1'b0));
    add("both_release",  0,0,0,0,0,0, e_edit(6'b000010, 1'b0, 1'b0));
    for (int j = 0; j < 10; j++)
      add("down_hold", 0,0,0,1,0,0, e_edit(6'b000010, 1'b0, (j == 0 || j == 8)));
    add("down_release",  0,0,0,0,0,0, e_edit(6'b000010, 1'b0, 1'b0));
    add("commit_enter",  1,0,0,0,0,0, e_com(3'd0));
    for (int f = 0; f < 6; f++) begin
      add("commit_wait_a", 1,0,1,0,1,0, e_com(3'(f)));
      add("commit_wait_b", 0,1,0,1,0,0, e_com(3'(f)));
      add("commit_ack",    0,0,0,0,0,1, (f == 5) ? e_idle(1'b0) : e_com(3'(f + 1)));
    end
    add("ack_in_idle",   0,0,0,0,0,1, e_idle(1'b0));
    add("idle_rd_again", 0,0,0,0,1,0, e_idle(1'b1));
    add("enter_edit",    1,0,0,0,0,0, e_edit(6'b000001, 1'b0, 1'b0));
    add("fast_commit",   1,0,0,0,0,0, e_com(3'd0));
    for (int f = 0; f < 6; f++)
      add("fast_ack", 0,0,0,0,0,1, (f == 5) ? e_idle(1'b0) : e_com(3'(f + 1)));
    add("to_enter",      1,0,0,0,0,0, e_edit(6'b000001, 1'b0, 1'b0));
    for (int k = 1; k < P_TO; k++)
      add("to_wait", 0,0,0,0,(k % 4 == 0),0, e_edit(6'b000001, 1'b0, 1'b0));
    add("to_expire",     0,0,0,0,0,0, e_idle(1'b0));
    add("to_reload",     0,0,0,0,1,0, e_idle(1'b1));
    add("to_after",      0,0,0,0,0,0, e_idle(1'b0));

    // ---- reset ----
    repeat (3) @(posedge CLK);
    #1;
    check("reset", obs, e_idle(1'b0));
    @(negedge CLK);
    RST = 1'b0;

    // ---- apply table through the scoreboard ----
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      EDIT = tbl[i].edit; NEXT = tbl[i].next; UP_IN = tbl[i].up_in;
      DOWN_IN = tbl[i].down_in; RD_STB = tbl[i].rd_stb; WR_ACK = tbl[i].wr_ack;
      sb_q.push_back(tbl[i]);
    end
    @(negedge CLK);
    EDIT = 0; NEXT = 0; UP_IN = 0; DOWN_IN = 0; RD_STB = 0; WR_ACK = 0;
    for (int k = 0; k < 4 && sb_q.size() != 0; k++) @(posedge CLK);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end

    // ---- reset in the middle of a write-back at WR_SEL=3 ----
    @(negedge CLK); EDIT = 1;
    @(negedge CLK); EDIT = 0;
    @(negedge CLK); EDIT = 1;
    @(negedge CLK); EDIT = 0; WR_ACK = 1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge CLK);
      #1;
      if (WR_SEL == 3'd3) found = 1'b1;
    end
    WR_ACK = 0;
    check("reach_sel3", obs, e_com(3'd3));
    #2;
    RST = 1'b1;
    #1;
    check("async_reset_mid_commit", obs, e_idle(1'b0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      WR_ACK = (k == 2);
      @(posedge CLK);
      #1;
      check($sformatf("post_reset_no_req[%0d]", k), obs, e_idle(1'b0));
    end
    WR_ACK = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_edit_sequencer.md
# rtc_edit_sequencer

Controller for the six BCD time/date field registers (seconds, minutes, hours, day, month, year) of the RTC interface. It arbitrates which register is in modification and converts the debounced button levels into single-cycle UP/DOWN pulses with auto-repeat. It gates the Actualizar load from RTC reads so that user edits are never overwritten. On exit from edit mode, it sequences the write-back of all six fields to the RTC write controller through a req/ack handshake.

## Interface
Parameters:
- REPEAT_DELAY, 50_000_000: cycles a button must be held before auto-repeat starts.
- REPEAT_RATE, 10_000_000: cycles between auto-repeat pulses.
- TIMEOUT, 1_000_000_000: idle cycles in edit mode before edits are abandoned.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- EDIT  in  1  one-cycle pulse from debounced button; enters or leaves edit mode.
- NEXT  in  1  one-cycle pulse; advances the selected field.
- UP_IN  in  1  debounced level, increment button.
- DOWN_IN  in  1  debounced level, decrement button.
- RD_STB  in  1  one-cycle pulse; an RTC read finished and new data is on the registers' DATA_in.
- WR_ACK  in  1  RTC write controller accepted the current field.
- MOD  out  6  one-hot Modificando per register: bit0 = seconds, then minutes, hours, day, month, bit5 = year.
- UP  out  1  one-cycle increment pulse, shared by all registers.
- DOWN  out  1  one-cycle decrement pulse, shared by all registers.
- ACT  out  1  one-cycle Actualizar pulse, shared by all registers.
- WR_REQ  out  1  write-back request.
- WR_SEL  out  3  index (0–5) of the field being written back.
- EDITING  out  1  high in EDIT state.

## Operation
- FSM states: IDLE, EDIT, COMMIT.
- All outputs are registered.

IDLE:
- MOD=0, UP=DOWN=0, WR_REQ=0.
- RD_STB produces ACT.
- EDIT → EDIT state with MOD=000001 (seconds).
- NEXT, UP_IN and DOWN_IN are ignored.

EDIT:
- EDITING=1. ACT is forced 0, including when RD_STB arrives.
- NEXT rotates the MOD one-hot left; bit5 wraps to bit0.
- A rising edge of UP_IN produces one UP pulse.
- While UP_IN stays held, a further pulse is issued after REPEAT_DELAY, then every REPEAT_RATE. DOWN_IN behaves the same way for DOWN.
- If UP_IN and DOWN_IN are both high, only UP is generated and the DOWN repeat counter is held cleared.
- In a cycle where MOD changes, UP and DOWN are forced 0 and both repeat counters are cleared.
- Inactivity counter:
  - Cleared by NEXT and by every emitted UP or DOWN pulse.
  - On reaching TIMEOUT: → IDLE, MOD=0, no write-back. The next RD_STB reloads the registers, discarding the edits.
- EDIT pulse → COMMIT, MOD=0.

COMMIT:
- WR_SEL starts at 0 and WR_REQ=1.
- WR_REQ is held until the cycle with WR_REQ && WR_ACK.
- After that cycle, WR_SEL increments and WR_REQ stays 1.
- After field 5 is acked: WR_REQ=0, WR_SEL=0, → IDLE.
- EDIT, NEXT, UP_IN, DOWN_IN and RD_STB are ignored; ACT=0.
- WR_ACK while WR_REQ=0 is ignored.

Counters:
- Each counter is sized to its parameter.
- Each counter saturates and never wraps.

## Timing
- Reset (asynchronous): state IDLE, MOD=0, UP=DOWN=ACT=0, WR_REQ=0, WR_SEL=0, EDITING=0, all counters 0. Reset mid-COMMIT abandons the write-back and asserts no further WR_REQ.
- EDIT sampled at cycle n: EDITING=1 and MOD=000001 at n+1.
- RD_STB at n in IDLE: ACT=1 at n+1 only.
- RD_STB in the same cycle as an EDIT in IDLE: the edit-mode transition wins and ACT stays 0.
- UP_IN first sampled high at n: UP=1 at n+1.
- UP_IN held continuously: UP pulses at n+1+REPEAT_DELAY, then every REPEAT_RATE cycles. Releasing UP_IN stops the pulses the next cycle and clears the counter.
- NEXT at n: MOD updated at n+1.
- Timeout: the transition to IDLE is visible TIMEOUT cycles after the last clearing event.
- WR_ACK at cycle m: WR_SEL advances at m+1. The ack of field 5 at m gives WR_REQ=0 and state IDLE at m+1. Minimum COMMIT duration is 6 cycles when ack is immediate.

## Test plan
- Reset mid-COMMIT at WR_SEL=3 → all outputs 0 next cycle, no further WR_REQ after release.
- IDLE with RD_STB pulse → ACT=1 exactly one cycle later. EDIT pulse, then RD_STB → ACT stays 0, MOD=000001.
- In EDIT, 6 NEXT pulses → MOD steps 000010…100000, then 000001. UP pulse coinciding with NEXT → no UP output that cycle.
- REPEAT_DELAY=8, REPEAT_RATE=4, UP_IN held 20 cycles from n → UP at n+1, n+9, n+13, n+17 and no others. UP_IN and DOWN_IN both held → DOWN never asserted.
- TIMEOUT=16, no activity after entering EDIT → EDITING falls 16 cycles later, MOD=0, WR_REQ never asserted.
- EDIT exit with WR_ACK delayed 2 cycles per field → WR_SEL 0..5 each held 3 cycles, WR_REQ low after the 6th ack, EDIT pulses during COMMIT ignored.
